cube: RTL and testbench

Sequential integer cube unit: y = a³ for an unsigned 4-bit operand, producing a 12-bit result. It is the inverse companion of the cube-root unit. Its 4-bit input accepts a root result directly, so the pair can round-trip check values: cube(cbrt(x)) ≤ x < cube(cbrt(x)+1). It uses one shift-add multiplier twice (a·a, then (a·a)·a) under a start/busy handshake.

---
 rtl/cube.sv | 102 ++++++++++
 tb/tb_cube.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/cube.sv
// Sequential 4-bit cube unit: y = a^3 using one shift-add multiplier twice,
// first for a*a and then for (a*a)*a, one multiplier bit per cycle.
module cube (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  a_bi,
  input  logic        start_i,
  output logic        busy_o,
  output logic [11:0] y_bo
);

  // Handshake: start_i is a level sampled on every rising edge and is
  // honoured only when the unit is idle (busy_o=0). busy_o rises on the
  // accepting edge and falls on the edge that publishes y_bo, so y_bo is
  // valid whenever busy_o is low.

  typedef enum logic [1:0] {IDLE, SQ, CB} state_t;

  state_t      state, state_nxt;
  logic [3:0]  x, x_nxt;
  logic [11:0] acc, acc_nxt;
  logic [7:0]  sq, sq_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic        busy_nxt;
  logic [11:0] y_nxt;
  logic [11:0] multiplicand;
  logic [11:0] addend;
  logic [11:0] acc_sum;

  // The multiplier operand is x in both phases; only the multiplicand changes.
  always_comb begin
    multiplicand = (state == CB) ? {4'b0, sq} : {8'b0, x};
    addend       = x[cnt] ? (multiplicand << cnt) : 12'd0;
    acc_sum      = acc + addend;
  end

  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    acc_nxt   = acc;
    sq_nxt    = sq;
    cnt_nxt   = cnt;
    busy_nxt  = busy_o;
    y_nxt     = y_bo;
    case (state)
      IDLE: begin
        if (start_i) begin
          x_nxt     = a_bi;
          acc_nxt   = 12'd0;
          cnt_nxt   = 2'd0;
          busy_nxt  = 1'b1;
          state_nxt = SQ;
        end
      end
      SQ: begin
        cnt_nxt = cnt + 2'd1;
        if (cnt == 2'd3) begin
          sq_nxt    = acc_sum[7:0];
          acc_nxt   = 12'd0;
          cnt_nxt   = 2'd0;
          state_nxt = CB;
        end else begin
          acc_nxt = acc_sum;
        end
      end
      CB: begin
        acc_nxt = acc_sum;
        cnt_nxt = cnt + 2'd1;
        if (cnt == 2'd3) begin
          y_nxt     = acc_sum;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      x      <= 4'd0;
      acc    <= 12'd0;
      sq     <= 8'd0;
      cnt    <= 2'd0;
      busy_o <= 1'b0;
      y_bo   <= 12'd0;
    end else begin
      state  <= state_nxt;
      x      <= x_nxt;
      acc    <= acc_nxt;
      sq     <= sq_nxt;
      cnt    <= cnt_nxt;
      busy_o <= busy_nxt;
      y_bo   <= y_nxt;
    end
  end

endmodule

// File: tb/tb_cube.sv
// Directed bench for the cube unit: latency, sweep, ignored starts,
// operand stability, reset abort and cube-root round trips.
module tb_cube;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  a_bi;
  logic        start_i;
  logic        busy_o;
  logic [11:0] y_bo;

  int checks = 0;
  int errors = 0;

  cube dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .a_bi    (a_bi),
    .start_i (start_i),
    .busy_o  (busy_o),
    .y_bo    (y_bo)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Called just after the acceptance edge; counts edges until busy_o falls.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (busy_o === 1'b1 && cyc < 20) begin
      @(posedge clk_i);
      @(negedge clk_i);
      cyc++;
    end
  endtask

  task automatic do_cube(input logic [3:0] a, output logic [11:0] y);
    int cyc;
    a_bi    = a;
    start_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    wait_done(cyc);
    check($sformatf("latency_a%0d", a), cyc, 8);
    y = y_bo;
  endtask

  logic [3:0]  sweep_a [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd15};
  logic [11:0] sweep_y [6] = '{12'd0, 12'd1, 12'd8, 12'd27, 12'd216, 12'hD2F};
  logic [7:0]  rt_x [8] = '{8'd1, 8'd8, 8'd9, 8'd28, 8'd68, 8'd125, 8'd200, 8'd255};
  logic [3:0]  rt_r [8] = '{4'd1, 4'd2, 4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd6};

  initial begin
    logic [11:0] y;
    int cyc;
    rst_i   = 1'b1;
    start_i = 1'b1;
    a_bi    = 4'd9;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_busy", busy_o, 0);
    check("reset_y", y_bo, 0);
    rst_i   = 1'b0;
    start_i = 1'b0;

    do_cube(4'd5, y);
    check("cube_5", y, 125);

    for (int i = 0; i < 6; i++) begin
      do_cube(sweep_a[i], y);
      check($sformatf("sweep_%0d", sweep_a[i]), y, sweep_y[i]);
    end

    // Starts at E2 and E8 are ignored while busy.
    a_bi = 4'd4; start_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);              // E0
    start_i = 1'b0;
    @(posedge clk_i); @(negedge clk_i);              // E1
    a_bi = 4'd9; start_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);              // E2
    start_i = 1'b0;
    check("pulse_busy_e2", busy_o, 1);
    repeat (5) begin @(posedge clk_i); @(negedge clk_i); end  // E3..E7
    check("pulse_busy_e7", busy_o, 1);
    start_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);              // E8
    start_i = 1'b0;
    check("pulse_busy_e8", busy_o, 0);
    check("pulse_y", y_bo, 64);
    @(posedge clk_i); @(negedge clk_i);              // E9
    check("pulse_no_rerun", busy_o, 0);
    check("pulse_y_hold", y_bo, 64);

    // Operand change after acceptance has no effect.
    a_bi = 4'd3; start_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    start_i = 1'b0; a_bi = 4'd15;
    check("hold_y_during", y_bo, 64);
    wait_done(cyc);
    check("hold_latency", cyc, 8);
    check("hold_y", y_bo, 27);

    // Reset at E5 aborts the run and clears the result.
    a_bi = 4'd7; start_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);              // E0
    start_i = 1'b0;
    repeat (4) begin @(posedge clk_i); @(negedge clk_i); end  // E1..E4
    rst_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);              // E5
    rst_i = 1'b0;
    check("abort_busy", busy_o, 0);
    check("abort_y", y_bo, 0);
    repeat (6) begin @(posedge clk_i); @(negedge clk_i); end
    check("abort_no_publish", y_bo, 0);
    do_cube(4'd2, y);
    check("after_abort", y, 8);

    // Round trip with cube-root results.
    for (int i = 0; i < 8; i++) begin
      do_cube(rt_r[i], y);
      check($sformatf("rt_le_%0d", rt_x[i]), (y <= {4'd0, rt_x[i]}), 1);
      if (rt_r[i] != 4'd15) begin
        do_cube(rt_r[i] + 4'd1, y);
        check($sformatf("rt_gt_%0d", rt_x[i]), (y > {4'd0, rt_x[i]}), 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
